host_byte_word_packer: RTL and testbench



---
 rtl/host_byte_word_packer.sv | 153 +++++++++++++++
 tb/tb_host_byte_word_packer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/host_byte_word_packer.sv
// Host byte-to-word packer feeding the 16-bit write port of the VRAM copy FIFO.
// The first byte of a pair becomes the low byte. Optional PACKER_OVERRUN_EN adds rejected-write tracking.
module host_byte_word_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       host_data,
  input  logic             host_wr,
  input  logic             host_flush,
  output logic             host_ready,
  output logic [15:0]      fifo_din,
  output logic             fifo_wr,
  input  logic             fifo_full,
  output logic [CNT_W-1:0] words_pushed,
  output logic             idle
`ifdef PACKER_OVERRUN_EN
  ,
  input  logic             overrun_clr,
  output logic             overrun,
  output logic [7:0]       drop_count
`endif
);

  // State encoding is {pend_valid, lo_valid}.
  typedef enum logic [1:0] {
    S_EMPTY   = 2'b00,
    S_HAVE_LO = 2'b01,
    S_PEND    = 2'b10,
    S_PEND_LO = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [7:0]         lo_byte_q, lo_byte_d;
  logic [15:0]        pend_word_q, pend_word_d;
  logic [CNT_W-1:0]   words_pushed_q, words_pushed_d;
  logic               flush_req_q, flush_req_d;

  logic lo_valid, pend_valid;
  logic lo_valid_d, pend_valid_d;
  logic drain_now, slot_free, wr_acc;

  assign lo_valid   = state_q[0];
  assign pend_valid = state_q[1];

  // The pending slot is usable on this edge if it is empty or its word drains now.
  assign drain_now  = pend_valid & ~fifo_full;
  assign slot_free  = ~pend_valid | drain_now;
  assign host_ready = ~lo_valid | slot_free;
  assign wr_acc     = host_wr & host_ready;

  assign fifo_wr      = drain_now;
  assign fifo_din     = pend_word_q;
  assign words_pushed = words_pushed_q;
  assign idle         = ~lo_valid & ~pend_valid & ~flush_req_q;

  always_comb begin
    lo_valid_d     = lo_valid;
    pend_valid_d   = pend_valid;
    lo_byte_d      = lo_byte_q;
    pend_word_d    = pend_word_q;
    flush_req_d    = flush_req_q;
    words_pushed_d = words_pushed_q;

    if (drain_now) begin
      pend_valid_d   = 1'b0;
      words_pushed_d = words_pushed_q + CNT_ONE;
    end

    if (wr_acc && !lo_valid) begin
      // A flush arriving with a low byte pads that byte on a later edge.
      lo_byte_d   = host_data;
      lo_valid_d  = 1'b1;
      flush_req_d = host_flush;
    end else if (wr_acc && lo_valid) begin
      // Completing a word makes any flush (new or latched) a no-op.
      pend_word_d  = {host_data, lo_byte_q};
      pend_valid_d = 1'b1;
      lo_valid_d   = 1'b0;
      flush_req_d  = 1'b0;
    end else if (lo_valid && (host_flush || flush_req_q)) begin
      if (slot_free) begin
        pend_word_d  = {PAD_BYTE, lo_byte_q};
        pend_valid_d = 1'b1;
        lo_valid_d   = 1'b0;
        flush_req_d  = 1'b0;
      end else begin
        flush_req_d  = 1'b1;
      end
    end

    state_d = state_t'({pend_valid_d, lo_valid_d});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_EMPTY;
      lo_byte_q      <= 8'h00;
      pend_word_q    <= 16'h0000;
      words_pushed_q <= '0;
      flush_req_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      lo_byte_q      <= lo_byte_d;
      pend_word_q    <= pend_word_d;
      words_pushed_q <= words_pushed_d;
      flush_req_q    <= flush_req_d;
    end
  end

`ifdef PACKER_OVERRUN_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       wr_rej;
  logic       overrun_q, overrun_d;
  logic [7:0] drop_count_q, drop_count_d;

  assign wr_rej = host_wr & ~host_ready;

  // A rejected write on the same edge as a clear wins over the clear.
  always_comb begin
    overrun_d    = overrun_q;
    drop_count_d = drop_count_q;
    if (overrun_clr) begin
      overrun_d    = 1'b0;
      drop_count_d = 8'h00;
    end
    if (wr_rej) begin
      overrun_d    = 1'b1;
      drop_count_d = sat_inc8(overrun_clr ? 8'h00 : drop_count_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q    <= 1'b0;
      drop_count_q <= 8'h00;
    end else begin
      overrun_q    <= overrun_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign overrun    = overrun_q;
  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_host_byte_word_packer.sv
// Directed bench for host_byte_word_packer; overrun checks build when PACKER_OVERRUN_EN is defined.
module tb_host_byte_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  host_data = 8'h00;
  logic        host_wr = 1'b0;
  logic        host_flush = 1'b0;
  logic        host_ready;
  logic [15:0] fifo_din;
  logic        fifo_wr;
  logic        fifo_full = 1'b0;
  logic [15:0] words_pushed;
  logic        idle;
`ifdef PACKER_OVERRUN_EN
  logic        overrun_clr = 1'b0;
  logic        overrun;
  logic [7:0]  drop_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  host_byte_word_packer #(.PAD_BYTE(8'h00), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .host_data(host_data), .host_wr(host_wr),
    .host_flush(host_flush), .host_ready(host_ready), .fifo_din(fifo_din),
    .fifo_wr(fifo_wr), .fifo_full(fifo_full), .words_pushed(words_pushed),
    .idle(idle)
`ifdef PACKER_OVERRUN_EN
    , .overrun_clr(overrun_clr), .overrun(overrun), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    cyc();
    cyc();
    check("rst_ready", 32'(host_ready), 32'd1);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    check("rst_fifo_din", 32'(fifo_din), 32'h0);
    check("rst_words", 32'(words_pushed), 32'd0);
    rst = 1'b0;
    cyc();

    // Basic pack: A5 then 5A -> 5AA5
    host_wr = 1'b1; host_data = 8'hA5;
    cyc();
    host_data = 8'h5A;
    #1;
    check("basic_ready_lo", 32'(host_ready), 32'd1);
    check("basic_no_wr_lo", 32'(fifo_wr), 32'd0);
    cyc();
    host_wr = 1'b0;
    #1;
    check("basic_fifo_wr", 32'(fifo_wr), 32'd1);
    check("basic_din", 32'(fifo_din), 32'h5AA5);
    check("basic_words_before", 32'(words_pushed), 32'd0);
    cyc();
    check("basic_wr_low", 32'(fifo_wr), 32'd0);
    check("basic_words", 32'(words_pushed), 32'd1);
    check("basic_idle", 32'(idle), 32'd1);

    // Odd flush: 3C padded to 003C, second flush does nothing
    host_wr = 1'b1; host_data = 8'h3C;
    cyc();
    host_wr = 1'b0; host_flush = 1'b1;
    cyc();
    host_flush = 1'b0;
    #1;
    check("flush_fifo_wr", 32'(fifo_wr), 32'd1);
    check("flush_din", 32'(fifo_din), 32'h003C);
    cyc();
    check("flush_words", 32'(words_pushed), 32'd2);
    host_flush = 1'b1;
    cyc();
    host_flush = 1'b0;
    #1;
    check("flush2_no_wr", 32'(fifo_wr), 32'd0);
    check("flush2_idle", 32'(idle), 32'd1);
    check("flush2_words", 32'(words_pushed), 32'd2);

    // Backpressure: full FIFO, bytes 11 22 33, 44 rejected
    fifo_full = 1'b1;
    host_wr = 1'b1; host_data = 8'h11;
    cyc();
    host_data = 8'h22;
    cyc();
    host_data = 8'h33;
    #1;
    check("bp_ready_pend", 32'(host_ready), 32'd1);
    check("bp_no_wr_pend", 32'(fifo_wr), 32'd0);
    cyc();
    host_data = 8'h44;
    #1;
    check("bp_not_ready", 32'(host_ready), 32'd0);
    check("bp_no_wr_full", 32'(fifo_wr), 32'd0);
    cyc();
    host_wr = 1'b0;
    #1;
    check("bp_still_not_ready", 32'(host_ready), 32'd0);
    check("bp_words_held", 32'(words_pushed), 32'd2);
`ifdef PACKER_OVERRUN_EN
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_drop1", 32'(drop_count), 32'd1);
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    #1;
    check("ovr_clr", 32'(overrun), 32'd0);
    check("ovr_clr_drop", 32'(drop_count), 32'd0);
    overrun_clr = 1'b1; host_wr = 1'b1; host_data = 8'h99;
    cyc();
    overrun_clr = 1'b0; host_wr = 1'b0;
    #1;
    check("ovr_set_wins", 32'(overrun), 32'd1);
    check("ovr_set_wins_drop", 32'(drop_count), 32'd1);
    host_wr = 1'b1; host_data = 8'h55;
    repeat (260) cyc();
    host_wr = 1'b0;
    #1;
    check("ovr_drop_sat", 32'(drop_count), 32'd255);
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    #1;
    check("ovr_sat_clr", 32'(drop_count), 32'd0);
`endif
    fifo_full = 1'b0;
    #1;
    check("bp_release_wr", 32'(fifo_wr), 32'd1);
    check("bp_release_din", 32'(fifo_din), 32'h2211);
    check("bp_release_ready", 32'(host_ready), 32'd1);
    host_wr = 1'b1; host_data = 8'h44;
    cyc();
    host_wr = 1'b0;
    #1;
    check("bp_second_wr", 32'(fifo_wr), 32'd1);
    check("bp_second_din", 32'(fifo_din), 32'h4433);
    check("bp_words3", 32'(words_pushed), 32'd3);
    cyc();
    check("bp_words4", 32'(words_pushed), 32'd4);
    check("bp_idle", 32'(idle), 32'd1);

    // Simultaneous write+flush from EMPTY -> 0077, padded one edge later
    host_wr = 1'b1; host_flush = 1'b1; host_data = 8'h77;
    cyc();
    host_wr = 1'b0; host_flush = 1'b0;
    #1;
    check("sim_e_not_idle", 32'(idle), 32'd0);
    check("sim_e_no_wr_yet", 32'(fifo_wr), 32'd0);
    cyc();
    check("sim_e_wr", 32'(fifo_wr), 32'd1);
    check("sim_e_din", 32'(fifo_din), 32'h0077);
    cyc();
    check("sim_e_words", 32'(words_pushed), 32'd5);
    check("sim_e_done", 32'(fifo_wr), 32'd0);
    check("sim_e_idle", 32'(idle), 32'd1);

    // Simultaneous from HAVE_LO(66) -> 7766, no padded word
    host_wr = 1'b1; host_data = 8'h66;
    cyc();
    host_flush = 1'b1; host_data = 8'h77;
    cyc();
    host_wr = 1'b0; host_flush = 1'b0;
    #1;
    check("sim_l_wr", 32'(fifo_wr), 32'd1);
    check("sim_l_din", 32'(fifo_din), 32'h7766);
    cyc();
    check("sim_l_no_pad", 32'(fifo_wr), 32'd0);
    check("sim_l_idle", 32'(idle), 32'd1);
    check("sim_l_words", 32'(words_pushed), 32'd6);

    // Async reset with a held word and a partial byte
    fifo_full = 1'b1;
    host_wr = 1'b1; host_data = 8'h12;
    cyc();
    host_data = 8'h34;
    cyc();
    host_data = 8'h56;
    cyc();
    host_wr = 1'b0; fifo_full = 1'b0;
    #1;
    check("ar_pre_wr", 32'(fifo_wr), 32'd1);
    rst = 1'b1;
    #1;
    check("ar_wr_drop", 32'(fifo_wr), 32'd0);
    check("ar_words0", 32'(words_pushed), 32'd0);
    check("ar_idle", 32'(idle), 32'd1);
    cyc();
    rst = 1'b0;
    cyc();
    host_wr = 1'b1; host_data = 8'hBE;
    cyc();
    host_data = 8'hEF;
    cyc();
    host_wr = 1'b0;
    #1;
    check("ar_wr", 32'(fifo_wr), 32'd1);
    check("ar_din", 32'(fifo_din), 32'hEFBE);
    cyc();
    check("ar_words1", 32'(words_pushed), 32'd1);
    check("ar_idle_end", 32'(idle), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
